// File: rtl/sdram_wt_cache.sv
// Direct-mapped write-through cache (one 32-bit word per line) in front of the SDRAM controller.
// Read hits are served from on-chip RAM; misses and all writes go through the mem_* handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a CPU request; RAM read issued at accept
// S_LOOKUP | tag compare; read hit completes, write hit merges into RAM
// S_FILL   | read miss outstanding on mem_*; fill line on mem_ready
// S_WRITE  | write-through outstanding on mem_*; complete on mem_ready
module sdram_wt_cache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [3:0]            cpu_wmask,
  input  logic [31:0]           cpu_din,
  output logic [31:0]           cpu_dout,
  output logic                  cpu_ready,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [31:0]             din_q, din_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic [31:0]             cpu_dout_q, cpu_dout_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]              mem_wmask_q, mem_wmask_d;
  logic [31:0]             mem_din_q, mem_din_d;
  logic [31:0]             hit_count_q, hit_count_d;
  logic [31:0]             miss_count_q, miss_count_d;

  logic [31:0]             data_ram [LINES];
  logic [TAG_BITS-1:0]     tag_ram  [LINES];
  logic [31:0]             ram_rdata_q;
  logic [TAG_BITS-1:0]     ram_rtag_q;
  logic [INDEX_BITS-1:0]   ram_addr;
  logic                    ram_we;
  logic                    ram_re;
  logic [31:0]             ram_wdata;

  logic [INDEX_BITS-1:0]   idx_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic                    hit;
  logic [31:0]             merged;
  logic                    unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign idx_q = addr_q[INDEX_BITS+1:2];
  assign tag_q = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit   = valid_q[idx_q] && (ram_rtag_q == tag_q);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wmask_q[i] ? din_q[8*i +: 8] : ram_rdata_q[8*i +: 8];
    end
  end

  // Single-port synchronous RAMs; the read is only launched when a request is accepted.
  always_ff @(posedge clk) begin
    if (ram_we && resetn) begin
      data_ram[ram_addr] <= ram_wdata;
      tag_ram[ram_addr]  <= tag_q;
    end
    if (ram_re) begin
      ram_rdata_q <= data_ram[ram_addr];
      ram_rtag_q  <= tag_ram[ram_addr];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wmask_d      = wmask_q;
    din_d        = din_q;
    valid_d      = valid_q;
    cpu_ready_d  = 1'b0;
    cpu_dout_d   = cpu_dout_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wmask_d  = mem_wmask_q;
    mem_din_d    = mem_din_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    ram_addr     = idx_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = merged;

    case (state_q)
      S_IDLE: begin
        ram_addr = cpu_addr[INDEX_BITS+1:2];
        if (cpu_valid && !cpu_ready_q) begin
          addr_d  = cpu_addr[ADDR_WIDTH-1:2];
          wmask_d = cpu_wmask;
          din_d   = cpu_din;
          ram_re  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (wmask_q == 4'h0) begin
          if (hit) begin
            cpu_dout_d  = ram_rdata_q;
            cpu_ready_d = 1'b1;
            hit_count_d = hit_count_q + 32'd1;
            state_d     = S_IDLE;
          end else begin
            miss_count_d = miss_count_q + 32'd1;
            mem_valid_d  = 1'b1;
            mem_addr_d   = {addr_q, 2'b00};
            mem_wmask_d  = 4'h0;
            mem_din_d    = din_q;
            state_d      = S_FILL;
          end
        end else begin
          // Write hits update the line now; misses leave the arrays untouched.
          ram_we      = hit;
          mem_valid_d = 1'b1;
          mem_addr_d  = {addr_q, 2'b00};
          mem_wmask_d = wmask_q;
          mem_din_d   = din_q;
          state_d     = S_WRITE;
        end
      end
      S_FILL: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d    = 1'b0;
          ram_we         = 1'b1;
          ram_wdata      = mem_dout;
          valid_d[idx_q] = 1'b1;
          cpu_dout_d     = mem_dout;
          cpu_ready_d    = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_WRITE: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wmask_q      <= '0;
      din_q        <= '0;
      valid_q      <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_dout_q   <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= '0;
      mem_din_q    <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wmask_q      <= wmask_d;
      din_q        <= din_d;
      valid_q      <= valid_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_dout_q   <= cpu_dout_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_din_q    <= mem_din_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_dout   = cpu_dout_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_din    = mem_din_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_sdram_wt_cache.sv
// Bench for sdram_wt_cache: directed scenarios plus random traffic against a
// line-level reference model and a behavioural SDRAM controller with programmable latency.
module tb_sdram_wt_cache;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [3:0]  cpu_wmask = '0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ready;
  logic        mem_valid;
  logic [24:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  sdram_wt_cache dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wmask(cpu_wmask), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  // Backing store seen by the controller model, and the bench's own view of memory.
  bit [31:0] ctl_mem [int];
  bit [31:0] ref_mem [int];

  function automatic bit [31:0] init_word(input int w);
    return (w * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction
  function automatic bit [31:0] ctl_get(input int w);
    return ctl_mem.exists(w) ? ctl_mem[w] : init_word(w);
  endfunction
  function automatic bit [31:0] ref_get(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction
  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] m);
    bit [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Reference cache: which word (by tag) each line holds.
  bit          ref_valid [256];
  bit [14:0]   ref_tag   [256];
  int unsigned ref_hits = 0;
  int unsigned ref_misses = 0;

  // Controller model
  int          ctl_delay = 0;
  int          ctl_reqs = 0;
  bit          ctl_abort;
  int          ctl_w;
  logic [24:0] cap_addr;
  logic [3:0]  cap_wmask;
  logic [31:0] cap_din;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (resetn && mem_valid && !mem_ready) begin
        ctl_abort = 1'b0;
        cap_addr  = mem_addr;
        cap_wmask = mem_wmask;
        cap_din   = mem_din;
        ctl_reqs++;
        for (int i = 0; i < ctl_delay; i++) begin
          @(posedge clk); #1;
          if (!resetn) begin
            ctl_abort = 1'b1;
            break;
          end
          chk("mem_hold", {mem_valid, mem_addr, mem_wmask, mem_din},
              {1'b1, cap_addr, cap_wmask, cap_din});
        end
        if (!ctl_abort) begin
          ctl_w = int'(cap_addr[24:2]);
          if (cap_wmask == 4'h0) mem_dout = ctl_get(ctl_w);
          else ctl_mem[ctl_w] = merge(ctl_get(ctl_w), cap_din, cap_wmask);
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_dout  = $urandom;
          chk("mem_valid_drop", mem_valid, 0);
        end
      end
    end
  end

  task automatic do_req(input logic [24:0] a, input logic [3:0] m, input logic [31:0] d,
                        input int dly, input string nm);
    int        idx, w, cycles, rises, first_mv, reqs0, exp_lat, exp_rises;
    bit [14:0] tag;
    bit        exp_hit, got_ready, prev_mv;
    bit [31:0] exp_data;
    idx     = int'(a[9:2]);
    tag     = a[24:10];
    w       = int'(a[24:2]);
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    ctl_delay = dly;
    reqs0   = ctl_reqs;
    @(negedge clk);
    while (cpu_ready) @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wmask = m; cpu_din = d;
    cycles = 0; got_ready = 0; rises = 0; first_mv = -1; prev_mv = mem_valid;
    while (!got_ready && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (mem_valid && !prev_mv) begin
        rises++;
        if (first_mv < 0) first_mv = cycles;
      end
      prev_mv = mem_valid;
      if (cpu_ready) got_ready = 1;
    end
    cpu_valid = 1'b0;

    if (m == 4'h0) begin
      if (exp_hit) ref_hits++;
      else begin
        ref_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
    end else begin
      ref_mem[w] = merge(ref_get(w), d, m);
    end
    exp_data  = ref_get(w);
    exp_rises = (m == 4'h0 && exp_hit) ? 0 : 1;
    exp_lat   = (m == 4'h0 && exp_hit) ? 2 : 3 + dly;

    chk({nm, "_ready"}, got_ready, 1);
    chk({nm, "_latency"}, cycles, exp_lat);
    chk({nm, "_mem_rises"}, rises, exp_rises);
    chk({nm, "_ctl_reqs"}, ctl_reqs - reqs0, exp_rises);
    if (exp_rises == 1) begin
      chk({nm, "_mv_cycle"}, first_mv, 2);
      chk({nm, "_mem_addr"}, cap_addr, {a[24:2], 2'b00});
      chk({nm, "_mem_wmask"}, cap_wmask, m);
      if (m != 4'h0) chk({nm, "_mem_din"}, cap_din, d);
    end
    if (m == 4'h0) begin
      chk({nm, "_dout"}, cpu_dout, exp_data);
      chk({nm, "_hits"}, hit_count, ref_hits);
      chk({nm, "_misses"}, miss_count, ref_misses);
      @(posedge clk); #1;
      chk({nm, "_dout_hold"}, {cpu_ready, cpu_dout}, {1'b0, exp_data});
    end
  endtask

  int          cyc;
  logic [24:0] ra;
  logic [3:0]  rm;

  initial begin
    ctl_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_dout", cpu_dout, 0);
    chk("rst_mem_bus", {mem_addr, mem_wmask, mem_din}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);

    do_req(25'h0000100, 4'h0, 32'h0, 3, "rd_miss");
    chk("first_data", cpu_dout, 32'hDEADBEEF);
    do_req(25'h0000100, 4'h0, 32'h0, 3, "rd_hit");
    do_req(25'h0000100, 4'b0011, 32'h12345678, 2, "wr_hit");
    do_req(25'h0000100, 4'h0, 32'h0, 2, "rd_merged");
    chk("merged_data", cpu_dout, 32'hDEAD5678);
    do_req(25'h0000500, 4'h0, 32'h0, 1, "alias_b");
    do_req(25'h0000100, 4'h0, 32'h0, 0, "alias_a");
    chk("alias_misses", miss_count, 3);
    do_req(25'h0000900, 4'hF, 32'hCAFEF00D, 1, "wr_miss");
    do_req(25'h0000900, 4'h0, 32'h0, 1, "no_alloc");
    chk("no_alloc_data", cpu_dout, 32'hCAFEF00D);
    do_req(25'h0003000, 4'h0, 32'h0, 20, "slow_rd");
    do_req(25'h0003000, 4'h5, 32'h11223344, 20, "slow_wr");
    do_req(25'h0000404, 4'h0, 32'h0, 2, "pre_rst_fill");
    do_req(25'h0000404, 4'h0, 32'h0, 2, "pre_rst_hit");

    // Abandon a fill by resetting while mem_ready is still pending.
    ctl_delay = 30;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 25'h0002000; cpu_wmask = 4'h0; cpu_din = '0;
    cyc = 0;
    while (!mem_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("midfill_mv_seen", mem_valid, 1);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("midfill_mem_valid", mem_valid, 0);
    chk("midfill_ready", cpu_ready, 0);
    chk("midfill_counts", {hit_count, miss_count}, 0);
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    ref_hits = 0;
    ref_misses = 0;
    do_req(25'h0000404, 4'h0, 32'h0, 2, "post_rst_miss");
    chk("post_rst_misscount", miss_count, 1);

    for (int n = 0; n < 80; n++) begin
      ra = {15'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rm = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      do_req(ra, rm, $urandom, $urandom_range(0, 4), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=%0d exp=%0d", n_checks, -1);
    $fatal(1, "bench time limit reached");
  end

endmodule
